// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage load/store controller: access sizes,
// FSM states and the address-width helper.
package mem_access_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_RSVD = 2'b10;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  typedef enum logic {
    IDLE      = 1'b0,
    RMW_WRITE = 1'b1
  } state_e;

  function automatic int clogb2(input int depth);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < depth) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Byte-lane extractor: picks the addressed byte/half out of a RAM word and
// extends it; the lane mask tells the store path which bits a sub-word write owns.
module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data,
  output logic [31:0] o_lane_mask
);

  logic [31:0] shifted;

  always_comb begin
    shifted     = i_word >> {i_offset, 3'b000};
    o_data      = i_word;
    o_lane_mask = '1;
    case (i_size)
      SIZE_BYTE: begin
        o_data      = {{24{~i_unsigned & shifted[7]}}, shifted[7:0]};
        o_lane_mask = 32'h0000_00FF << {i_offset, 3'b000};
      end
      SIZE_HALF: begin
        o_data      = {{16{~i_unsigned & shifted[15]}}, shifted[15:0]};
        o_lane_mask = 32'h0000_FFFF << {i_offset[1], 4'b0000};
      end
      default: begin
        o_data      = i_word;
        o_lane_mask = '1;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller in front of a single-port word RAM that
// reads/writes on the falling edge; sub-word stores become a 2-cycle read-modify-write.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 1024,
  localparam int ADDR_W   = clogb2(RAM_DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic                 i_mem_read,
  input  logic                 i_mem_write,
  input  logic [1:0]           i_size,
  input  logic                 i_unsigned,
  input  logic [31:0]          i_addr,
  input  logic [RAM_WIDTH-1:0] i_wdata,
  input  logic [RAM_WIDTH-1:0] i_mem_rdata,
  output logic [ADDR_W-1:0]    o_mem_addr,
  output logic [RAM_WIDTH-1:0] o_mem_wdata,
  output logic                 o_mem_we,
  output logic                 o_stall,
  output logic [RAM_WIDTH-1:0] o_rdata,
  output logic                 o_rdata_valid,
  output logic                 o_fault
);

  state_e      state_q;
  logic [31:0] merge_q;
  logic [31:0] merge_d;
  logic [31:0] rdata_q;
  logic        rdata_valid_q;
  logic        fault_q;

  logic        is_req, illegal, legal;
  logic        do_load, do_wstore, do_sstore, in_idle;
  logic [31:0] aligned, lane_mask, wdata_rep;
  logic        unused_addr_bits;

  // Address bits above the RAM depth are deliberately dropped so accesses wrap.
  assign unused_addr_bits = ^i_addr[31:ADDR_W+2];

  assign is_req  = i_valid & (i_mem_read | i_mem_write);
  assign illegal = (i_mem_read & i_mem_write)
                 | (i_size == SIZE_RSVD)
                 | ((i_size == SIZE_HALF) & i_addr[0])
                 | ((i_size == SIZE_WORD) & (i_addr[1:0] != 2'b00));
  assign legal     = is_req & ~illegal;
  assign do_load   = legal & i_mem_read;
  assign do_wstore = legal & i_mem_write & (i_size == SIZE_WORD);
  assign do_sstore = legal & i_mem_write & (i_size != SIZE_WORD);
  assign in_idle   = (state_q == IDLE);

  load_align u_align (
    .i_word      (i_mem_rdata),
    .i_offset    (i_addr[1:0]),
    .i_size      (i_size),
    .i_unsigned  (i_unsigned),
    .o_data      (aligned),
    .o_lane_mask (lane_mask)
  );

  assign wdata_rep = (i_size == SIZE_BYTE) ? {4{i_wdata[7:0]}} : {2{i_wdata[15:0]}};
  assign merge_d   = (i_mem_rdata & ~lane_mask) | (wdata_rep & lane_mask);

  // Reset gates the strobes directly so an in-flight RMW write is dropped at once.
  assign o_mem_addr  = i_addr[ADDR_W+1:2];
  assign o_mem_wdata = (state_q == RMW_WRITE) ? merge_q : i_wdata;
  assign o_mem_we    = ~i_reset & ((in_idle & do_wstore) | (state_q == RMW_WRITE));
  assign o_stall     = ~i_reset & in_idle & do_sstore;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= IDLE;
      merge_q       <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      rdata_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (is_req & illegal) begin
            fault_q <= 1'b1;
          end else if (do_load) begin
            rdata_q       <= aligned;
            rdata_valid_q <= 1'b1;
          end else if (do_sstore) begin
            merge_q <= merge_d;
            state_q <= RMW_WRITE;
          end
        end
        RMW_WRITE: state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  assign o_rdata       = rdata_q;
  assign o_rdata_valid = rdata_valid_q;
  assign o_fault       = fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a falling-edge word RAM model
// (BRAM[i]=i at start) and a queue of expected load results.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, rd, wr, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [31:0] mem_rdata;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we, stall, rdata_valid, fault;
  logic [31:0] rdata;

  logic [31:0] bram [1024];
  logic [31:0] exp_q [$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          stall_cnt = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.RAM_WIDTH(32), .RAM_DEPTH(1024)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_valid       (valid),
    .i_mem_read    (rd),
    .i_mem_write   (wr),
    .i_size        (size),
    .i_unsigned    (uns),
    .i_addr        (addr),
    .i_wdata       (wdata),
    .i_mem_rdata   (mem_rdata),
    .o_mem_addr    (mem_addr),
    .o_mem_wdata   (mem_wdata),
    .o_mem_we      (mem_we),
    .o_stall       (stall),
    .o_rdata       (rdata),
    .o_rdata_valid (rdata_valid),
    .o_fault       (fault)
  );

  // Data_memory, LOW_LATENCY: read-first word RAM clocked on the falling edge.
  initial begin
    mem_rdata = '0;
    for (int i = 0; i < 1024; i++) bram[i] = 32'(i);
    forever begin
      @(negedge clk);
      mem_rdata <= bram[mem_addr];
      if (mem_we) bram[mem_addr] = mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic r, input logic w, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] d);
    valid = 1'b1; rd = r; wr = w; size = sz; uns = u; addr = a; wdata = d;
  endtask

  task automatic idle();
    valid = 1'b0; rd = 1'b0; wr = 1'b0; size = 2'b00; uns = 1'b0; addr = '0; wdata = '0;
  endtask

  // One clock of the current request: strobes checked mid-cycle, registered outputs after the edge.
  task automatic tick(input string tag, input logic exp_we, input logic exp_stall,
                      input logic exp_fault, input logic exp_valid);
    @(negedge clk); #1;
    chk({tag, "_we"}, 32'(mem_we), 32'(exp_we));
    chk({tag, "_stall"}, 32'(stall), 32'(exp_stall));
    if (stall) stall_cnt++;
    @(posedge clk); #1;
    chk({tag, "_fault"}, 32'(fault), 32'(exp_fault));
    chk({tag, "_valid"}, 32'(rdata_valid), 32'(exp_valid));
    if (rdata_valid && exp_q.size() > 0) chk({tag, "_rdata"}, rdata, exp_q.pop_front());
    $display("txn %-10s we=%0b stall=%0b fault=%0b valid=%0b rdata=%08h",
             tag, mem_we, stall, fault, rdata_valid, rdata);
  endtask

  task automatic load(input string tag, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] exp);
    req(1'b1, 1'b0, sz, u, a, 32'h0);
    exp_q.push_back(exp);
    tick(tag, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_valid", 32'(rdata_valid), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Word store then load
    req(1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'hDEADBEEF);
    tick("sw10", 1'b1, 1'b0, 1'b0, 1'b0);
    load("lw10", 2'b11, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("mem_w4", bram[4], 32'hDEADBEEF);

    // Byte store read-modify-write
    req(1'b0, 1'b1, 2'b11, 1'b0, 32'h20, 32'h11223344);
    tick("sw20", 1'b1, 1'b0, 1'b0, 1'b0);
    req(1'b0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA);
    tick("sb21_rd", 1'b0, 1'b1, 1'b0, 1'b0);
    tick("sb21_wr", 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    tick("idle", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mem_w8", bram[8], 32'h1122AA44);

    // Sign/zero extension, back-to-back loads
    req(1'b0, 1'b1, 2'b11, 1'b0, 32'h30, 32'h80FF7F01);
    tick("sw30", 1'b1, 1'b0, 1'b0, 1'b0);
    load("lb31", 2'b00, 1'b0, 32'h31, 32'h0000007F);
    load("lb32", 2'b00, 1'b0, 32'h32, 32'hFFFFFFFF);
    load("lbu32", 2'b00, 1'b1, 32'h32, 32'h000000FF);
    load("lh32", 2'b01, 1'b0, 32'h32, 32'hFFFF80FF);
    load("lhu32", 2'b01, 1'b1, 32'h32, 32'h000080FF);

    // Illegal requests
    req(1'b1, 1'b0, 2'b01, 1'b0, 32'h3, 32'h0);
    tick("f_lh3", 1'b0, 1'b0, 1'b1, 1'b0);
    req(1'b0, 1'b1, 2'b11, 1'b0, 32'h6, 32'h12345678);
    tick("f_sw6", 1'b0, 1'b0, 1'b1, 1'b0);
    req(1'b1, 1'b1, 2'b11, 1'b0, 32'h10, 32'h0BADF00D);
    tick("f_rdwr", 1'b0, 1'b0, 1'b1, 1'b0);
    req(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hFFFFFFFF);
    tick("f_sz10", 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    tick("idle", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mem_w0", bram[0], 32'h0);
    chk("mem_w1", bram[1], 32'h1);
    chk("mem_w4b", bram[4], 32'hDEADBEEF);
    chk("mem_w8b", bram[8], 32'h1122AA44);

    // Reset while the RMW write is pending
    req(1'b0, 1'b1, 2'b01, 1'b0, 32'h40, 32'h0000BEEF);
    tick("sh40_rd", 1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("rmw_rst_we", 32'(mem_we), 32'h0);
    chk("rmw_rst_stall", 32'(stall), 32'h0);
    chk("rmw_rst_rdata", rdata, 32'h0);
    chk("rmw_rst_valid", 32'(rdata_valid), 32'h0);
    @(negedge clk); #1;
    chk("rmw_rst_we_neg", 32'(mem_we), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    chk("mem_w16", bram[16], 32'h10);
    load("lw40", 2'b11, 1'b0, 32'h40, 32'h00000010);

    // Mixed stream with address wrap
    stall_cnt = 0;
    req(1'b0, 1'b1, 2'b00, 1'b0, 32'h22, 32'h00000055);
    tick("sb22_rd", 1'b0, 1'b1, 1'b0, 1'b0);
    tick("sb22_wr", 1'b1, 1'b0, 1'b0, 1'b0);
    load("lw20", 2'b11, 1'b0, 32'h20, 32'h1155AA44);
    load("lw1010", 2'b11, 1'b0, 32'h1010, 32'hDEADBEEF);
    req(1'b0, 1'b1, 2'b11, 1'b0, 32'h2024, 32'hCAFEF00D);
    tick("sw2024", 1'b1, 1'b0, 1'b0, 1'b0);
    load("lb27", 2'b00, 1'b0, 32'h27, 32'hFFFFFFCA);
    idle();
    tick("idle", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("stream_stalls", 32'(stall_cnt), 32'd1);
    chk("mem_w9", bram[9], 32'hCAFEF00D);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
